// File: rtl/psum_acc_pkg.sv
// Shared types and lane arithmetic for the psum accumulation buffer.
package psum_acc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StDrain
  } state_e;

  // Widest lane the helpers support; lanes are sign-extended to this width on entry.
  localparam int unsigned MaxBw = 32;

  // Signed add of two sign-extended lanes, clamped to the range of a bw-bit signed value.
  function automatic logic signed [MaxBw-1:0] sat_add(input logic signed [MaxBw-1:0] a,
                                                      input logic signed [MaxBw-1:0] b,
                                                      input int unsigned             bw);
    logic signed [MaxBw:0] sum;
    logic signed [MaxBw:0] hi;
    logic signed [MaxBw:0] lo;
    sum = (MaxBw+1)'(a) + (MaxBw+1)'(b);
    hi  = ((MaxBw+1)'(1) << (bw - 1)) - (MaxBw+1)'(1);
    lo  = -((MaxBw+1)'(1) << (bw - 1));
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return sum[MaxBw-1:0];
  endfunction

  // max(0, x) on a sign-extended lane.
  function automatic logic signed [MaxBw-1:0] relu_lane(input logic signed [MaxBw-1:0] x);
    return x[MaxBw-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/psum_mem_1r1w.sv
// Behavioural 1R1W storage array: synchronous read, one-cycle latency,
// read returns the old contents when the same entry is written in that cycle.
module psum_mem_1r1w #(
  parameter int unsigned depth = 1024,
  parameter int unsigned width = 128,
  parameter int unsigned aw    = $clog2(depth)
) (
  input  logic             clk,
  input  logic             re,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata
);

  logic [width-1:0] mem_q [depth];

  // Write and registered read; non-blocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/psum_acc_buffer.sv
// Psum accumulation buffer: in-place saturating accumulate of column vectors,
// then a handshaked drain of a contiguous (wrapping) address range with optional ReLU.
module psum_acc_buffer
  import psum_acc_pkg::*;
#(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 8,
  parameter int unsigned depth   = 1024,
  // Derived from depth; not meant to be overridden.
  parameter int unsigned aw      = $clog2(depth)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  input  logic [aw-1:0]          acc_addr,
  input  logic                   acc_first,
  input  logic [col*psum_bw-1:0] acc_data,
  input  logic                   drain_start,
  input  logic [aw-1:0]          drain_base,
  input  logic [aw:0]            drain_len,
  input  logic                   relu,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [col*psum_bw-1:0] out_data,
  output logic                   busy,
  output logic                   drain_done
);

  localparam int unsigned vec_w = col * psum_bw;

  state_e state_q, state_d;

  // Accumulate pipeline stage 1 and forwarding register.
  logic             acc_fire;
  logic             s1_valid_q;
  logic [aw-1:0]    s1_addr_q;
  logic             s1_first_q;
  logic [vec_w-1:0] s1_data_q;
  logic             fwd_valid_q;
  logic [aw-1:0]    fwd_addr_q;
  logic [vec_w-1:0] fwd_data_q;
  logic [vec_w-1:0] old_vec;
  logic [vec_w-1:0] new_vec;

  // Storage port signals.
  logic             mem_re;
  logic [aw-1:0]    mem_raddr;
  logic [vec_w-1:0] mem_rdata;

  // Drain control and the two-entry output queue.
  logic             drain_active;
  logic             drain_re;
  logic             drain_last;
  logic             slot_ok;
  logic [1:0]       occ;
  logic [aw-1:0]    rd_addr_q;
  logic [aw:0]      rd_rem_q;
  logic [aw:0]      out_rem_q;
  logic             relu_q;
  logic             rd_pend_q;
  logic             drain_done_q;
  logic [vec_w-1:0] q_data_q [2];
  logic             q_wptr_q;
  logic             q_rptr_q;
  logic [1:0]       q_cnt_q, q_cnt_d;
  logic             out_hs;
  logic [vec_w-1:0] q_head;
  logic [vec_w-1:0] q_head_relu;

  assign acc_fire = acc_valid & acc_ready;
  assign out_hs   = out_valid & out_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; drain_start outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (drain_start) state_d = StFlush;
      StFlush: if (!s1_valid_q) state_d = StDrain;
      StDrain: if (drain_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    acc_ready    = (state_q == StIdle);
    drain_active = (state_q == StDrain);
    busy         = (state_q != StIdle) || s1_valid_q;
  end

  // Pipeline and forwarding valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      fwd_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= acc_fire;
      fwd_valid_q <= s1_valid_q;
    end
  end

  // Pipeline and forwarding payload; no reset needed behind the valid bits.
  always_ff @(posedge clk) begin
    if (acc_fire) begin
      s1_addr_q  <= acc_addr;
      s1_first_q <= acc_first;
      s1_data_q  <= acc_data;
    end
    if (s1_valid_q) begin
      fwd_addr_q <= s1_addr_q;
      fwd_data_q <= new_vec;
    end
  end

  // The RAM read for a back-to-back same-address accept was issued before the
  // previous write landed, so the just-committed value must be taken instead.
  assign old_vec = (fwd_valid_q && (fwd_addr_q == s1_addr_q)) ? fwd_data_q : mem_rdata;

  for (genvar i = 0; i < col; i++) begin : g_lane
    logic signed [psum_bw-1:0] in_l;
    logic signed [psum_bw-1:0] old_l;
    logic signed [psum_bw-1:0] sum_l;
    logic signed [psum_bw-1:0] head_l;

    assign in_l   = s1_data_q[i*psum_bw +: psum_bw];
    assign old_l  = old_vec[i*psum_bw +: psum_bw];
    assign sum_l  = psum_bw'(sat_add(MaxBw'(old_l), MaxBw'(in_l), psum_bw));
    assign new_vec[i*psum_bw +: psum_bw] = s1_first_q ? in_l : sum_l;

    assign head_l = q_head[i*psum_bw +: psum_bw];
    assign q_head_relu[i*psum_bw +: psum_bw] =
        relu_q ? psum_bw'(relu_lane(MaxBw'(head_l))) : head_l;
  end

  // Only one requester uses the read port at a time: accumulates in IDLE, drain reads in DRAIN.
  assign mem_re    = acc_fire | drain_re;
  assign mem_raddr = drain_re ? rd_addr_q : acc_addr;

  psum_mem_1r1w #(
    .depth(depth),
    .width(vec_w),
    .aw   (aw)
  ) u_mem (
    .clk  (clk),
    .re   (mem_re),
    .raddr(mem_raddr),
    .rdata(mem_rdata),
    .we   (s1_valid_q),
    .waddr(s1_addr_q),
    .wdata(new_vec)
  );

  // A read may issue only if its return finds a slot even when nothing pops that cycle.
  assign occ        = q_cnt_q + {1'b0, rd_pend_q};
  assign slot_ok    = (occ < 2'd2) || out_hs;
  assign drain_re   = drain_active && (rd_rem_q != '0) && slot_ok;
  assign drain_last = (out_rem_q == '0) || ((out_rem_q == (aw+1)'(1)) && out_hs);

  // Drain address/count bookkeeping and the registered done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q    <= '0;
      rd_rem_q     <= '0;
      out_rem_q    <= '0;
      relu_q       <= 1'b0;
      rd_pend_q    <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      if ((state_q == StIdle) && drain_start) begin
        rd_addr_q <= drain_base;
        rd_rem_q  <= drain_len;
        out_rem_q <= drain_len;
        relu_q    <= relu;
      end else begin
        if (drain_re) begin
          rd_addr_q <= rd_addr_q + aw'(1);
          rd_rem_q  <= rd_rem_q - (aw+1)'(1);
        end
        if (out_hs) begin
          out_rem_q <= out_rem_q - (aw+1)'(1);
        end
      end
      rd_pend_q    <= drain_re;
      drain_done_q <= drain_active && drain_last;
    end
  end

  // Output queue occupancy.
  always_comb begin
    q_cnt_d = q_cnt_q;
    if (rd_pend_q && !out_hs) begin
      q_cnt_d = q_cnt_q + 2'd1;
    end else if (!rd_pend_q && out_hs) begin
      q_cnt_d = q_cnt_q - 2'd1;
    end
  end

  // Output queue pointers and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_wptr_q <= 1'b0;
      q_rptr_q <= 1'b0;
      q_cnt_q  <= '0;
    end else begin
      if (rd_pend_q) begin
        q_wptr_q <= ~q_wptr_q;
      end
      if (out_hs) begin
        q_rptr_q <= ~q_rptr_q;
      end
      q_cnt_q <= q_cnt_d;
    end
  end

  // Output queue payload: capture the drained RAM word the cycle after its read.
  always_ff @(posedge clk) begin
    if (rd_pend_q) begin
      q_data_q[q_wptr_q] <= mem_rdata;
    end
  end

  assign q_head     = q_data_q[q_rptr_q];
  assign out_valid  = (q_cnt_q != '0);
  assign out_data   = out_valid ? q_head_relu : '0;
  assign drain_done = drain_done_q;

endmodule

// File: tb/tb_psum_acc_buffer.sv
// Directed self-checking bench for psum_acc_buffer (4 lanes x 16 bit, 16 entries).
module tb_psum_acc_buffer;

  localparam int unsigned PBW   = 16;
  localparam int unsigned COL   = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          acc_valid;
  logic          acc_ready;
  logic [AW-1:0] acc_addr;
  logic          acc_first;
  logic [63:0]   acc_data;
  logic          drain_start;
  logic [AW-1:0] drain_base;
  logic [AW:0]   drain_len;
  logic          relu;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic          busy;
  logic          drain_done;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  psum_acc_buffer #(
    .psum_bw(PBW),
    .col    (COL),
    .depth  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_addr   (acc_addr),
    .acc_first  (acc_first),
    .acc_data   (acc_data),
    .drain_start(drain_start),
    .drain_base (drain_base),
    .drain_len  (drain_len),
    .relu       (relu),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .drain_done (drain_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] mk4(input int a3, input int a2, input int a1, input int a0);
    return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  function automatic logic [63:0] vec(input int v);
    return mk4(v, v, v, v);
  endfunction

  // One accumulate beat, driven at a falling edge; consecutive calls are back-to-back.
  task automatic acc(input logic [AW-1:0] a, input logic f, input logic [63:0] d);
    acc_valid = 1'b1;
    acc_addr  = a;
    acc_first = f;
    acc_data  = d;
    @(negedge clk);
    acc_valid = 1'b0;
  endtask

  task automatic kick(input logic [AW-1:0] b, input logic [AW:0] n, input logic r);
    drain_base  = b;
    drain_len   = n;
    relu        = r;
    drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
  endtask

  // Consume a drain against exp_q, checking order, stall stability, count and done pulse.
  task automatic collect(input int n, input bit rnd, input bit consec, input string tag);
    int got   = 0;
    int done  = 0;
    int first = -1;
    int last  = -1;
    bit stalled = 1'b0;
    logic [63:0] held = '0;
    for (int c = 0; c < 200; c++) begin
      if (stalled) begin
        chk({tag, "_hold"}, {out_valid, out_data}, {1'b1, held});
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
      if (out_valid) begin
        if (!out_ready) begin
          stalled = 1'b1;
          held    = out_data;
        end else begin
          if (got < n) chk({tag, "_data"}, out_data, exp_q[got]);
          else chk({tag, "_extra"}, out_valid, 0);
          if (first < 0) first = c;
          last = c;
          got++;
        end
      end
      @(negedge clk);
      if (drain_done) begin
        done++;
        break;
      end
    end
    out_ready = 1'b0;
    chk({tag, "_count"}, got, n);
    chk({tag, "_done"}, done, 1);
    if (consec) chk({tag, "_consec"}, last - first, n - 1);
    @(negedge clk);
    chk({tag, "_pulse"}, {drain_done, busy}, 0);
  endtask

  initial begin
    reset       = 1'b1;
    acc_valid   = 1'b0;
    acc_addr    = '0;
    acc_first   = 1'b0;
    acc_data    = '0;
    drain_start = 1'b0;
    drain_base  = '0;
    drain_len   = '0;
    relu        = 1'b0;
    out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_acc_ready", acc_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single overwrite then drain of one entry.
    acc(4'd5, 1'b1, vec(3));
    chk("busy_pipe", busy, 1);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    exp_q.delete();
    exp_q.push_back(vec(3));
    kick(4'd5, 5'd1, 1'b0);
    collect(1, 1'b0, 1'b0, "t1");

    // Back-to-back same-address accumulates; the last beat shares its cycle with drain_start.
    acc(4'd7, 1'b1, vec(10));
    acc(4'd7, 1'b0, vec(20));
    acc_valid = 1'b1;
    acc_addr  = 4'd7;
    acc_first = 1'b0;
    acc_data  = vec(-5);
    kick(4'd7, 5'd1, 1'b0);
    acc_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back(vec(25));
    collect(1, 1'b0, 1'b0, "t2fwd");

    // Accumulates one idle cycle apart go through the RAM path.
    acc(4'd7, 1'b0, vec(100));
    @(negedge clk);
    acc(4'd7, 1'b0, vec(1));
    exp_q.delete();
    exp_q.push_back(vec(126));
    kick(4'd7, 5'd1, 1'b0);
    collect(1, 1'b0, 1'b0, "t2ram");

    // Saturation at both rails with mixed lanes.
    acc(4'd0, 1'b1, mk4(100, -100, 32767, 32000));
    acc(4'd0, 1'b0, mk4(23, -50, 1, 1000));
    acc(4'd1, 1'b1, vec(-32000));
    acc(4'd1, 1'b0, vec(-1000));
    exp_q.delete();
    exp_q.push_back(mk4(123, -150, 32767, 32767));
    exp_q.push_back(vec(-32768));
    kick(4'd0, 5'd2, 1'b0);
    collect(2, 1'b0, 1'b0, "t3sat");

    // Address wrap-around.
    acc(4'd14, 1'b1, vec(1));
    acc(4'd15, 1'b1, vec(2));
    acc(4'd0, 1'b1, vec(3));
    acc(4'd1, 1'b1, vec(4));
    exp_q.delete();
    for (int i = 1; i <= 4; i++) exp_q.push_back(vec(i));
    kick(4'd14, 5'd4, 1'b0);
    collect(4, 1'b0, 1'b0, "t4wrap");

    // Backpressure, then full rate.
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      acc(4'(2 + i), 1'b1, mk4(i * 10 + 3, -i, i, 100 + i));
      exp_q.push_back(mk4(i * 10 + 3, -i, i, 100 + i));
    end
    kick(4'd2, 5'd8, 1'b0);
    collect(8, 1'b1, 1'b0, "t5rnd");
    kick(4'd2, 5'd8, 1'b0);
    collect(8, 1'b0, 1'b1, "t5seq");

    // Zero-length drain.
    exp_q.delete();
    kick(4'd0, 5'd0, 1'b0);
    collect(0, 1'b0, 1'b0, "len0");

    // ReLU latched at drain_start, then without it.
    acc(4'd3, 1'b1, mk4(-4, 6, -4, 6));
    exp_q.delete();
    exp_q.push_back(mk4(0, 6, 0, 6));
    kick(4'd3, 5'd1, 1'b1);
    relu = 1'b0;
    collect(1, 1'b0, 1'b0, "relu1");
    exp_q.delete();
    exp_q.push_back(mk4(-4, 6, -4, 6));
    kick(4'd3, 5'd1, 1'b0);
    collect(1, 1'b0, 1'b0, "relu0");

    // Reset in the middle of a stalled drain.
    out_ready = 1'b0;
    kick(4'd2, 5'd8, 1'b0);
    repeat (4) @(negedge clk);
    chk("mid_valid", {out_valid, busy}, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset", {out_valid, drain_done, busy, acc_ready}, 4'b0001);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset", {out_valid, drain_done}, 0);
    end
    exp_q.delete();
    exp_q.push_back(mk4(-4, 6, -4, 6));
    kick(4'd3, 5'd1, 1'b0);
    collect(1, 1'b0, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
